// File: rtl/lane_arb_pkg.sv
// Shared constants and helpers for the four-lane round-robin arbiter.
package lane_arb_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_ID_W = 2;

    typedef logic [LANE_ID_W-1:0] lane_id_t;

    localparam lane_id_t PTR_RESET = 2'd0;

    // One-hot grant vector for a lane index.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_id_t lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-find-first lane selector.
// With LANE_ARB... see top: LANE_RR_ARBITER_PRIO0_EN gives lane 0 strict priority.
module rr_pick
    import lane_arb_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  lane_id_t             ptr,
    output lane_id_t             g,
    output logic                 any_req
);

    logic [NUM_LANES-1:0] req_rr_s;
    lane_id_t             idx_s;
    lane_id_t             rr_g_s;
    logic                 found_s;

`ifdef LANE_RR_ARBITER_PRIO0_EN
    assign req_rr_s = req & 4'b1110;
`else
    assign req_rr_s = req;
`endif

    // First requesting lane at or after ptr, wrapping from lane 3 to lane 0.
    always_comb begin
        rr_g_s  = 2'd0;
        found_s = 1'b0;
        idx_s   = ptr;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx_s = ptr + LANE_ID_W'(i);
            if (!found_s && req_rr_s[idx_s]) begin
                rr_g_s  = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

`ifdef LANE_RR_ARBITER_PRIO0_EN
    assign g = req[0] ? 2'd0 : rr_g_s;
`else
    assign g = rr_g_s;
`endif

    assign any_req = |req;

endmodule

// File: rtl/lane_rr_arbiter.sv
// Four-lane round-robin arbiter feeding a single registered output stage.
// Optional build macro LANE_RR_ARBITER_PRIO0_EN gives lane 0 strict priority.
module lane_rr_arbiter
    import lane_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] in_valid,
    input  logic [WIDTH-1:0]     in_data0,
    input  logic [WIDTH-1:0]     in_data1,
    input  logic [WIDTH-1:0]     in_data2,
    input  logic [WIDTH-1:0]     in_data3,
    output logic [NUM_LANES-1:0] in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [LANE_ID_W-1:0] out_id,
    input  logic                 out_ready
);

    lane_id_t         ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    lane_id_t         out_id_q, out_id_d;

    lane_id_t         grant_s;
    logic             any_req_s;
    logic             accept_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;

    rr_pick u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .g       (grant_s),
        .any_req (any_req_s)
    );

    assign accept_s = !out_valid_q || out_ready;
    assign xfer_s   = any_req_s && accept_s && !reset;

    // Grant depends only on valid bits and pointer, never on payload.
    always_comb begin
        if (xfer_s) begin
            in_ready = lane_onehot(grant_s);
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Payload mux for the granted lane.
    always_comb begin
        case (grant_s)
            2'd0:    sel_data_s = in_data0;
            2'd1:    sel_data_s = in_data1;
            2'd2:    sel_data_s = in_data2;
            2'd3:    sel_data_s = in_data3;
            default: sel_data_s = in_data0;
        endcase
    end

    // Next-state for the output register and rotation pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_id_d    = grant_s;
`ifdef LANE_RR_ARBITER_PRIO0_EN
            if (grant_s == 2'd0) begin
                ptr_d = ptr_q;
            end else begin
                ptr_d = grant_s + 2'd1;
            end
`else
            ptr_d = grant_s + 2'd1;
`endif
        end else if (accept_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any held word immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_id_q    <= 2'd0;
            ptr_q       <= PTR_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Self-checking bench for lane_rr_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_lane_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] in_valid;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    // reference model state
    int       m_ptr;
    logic     m_valid;
    logic [7:0] m_data;
    int       m_id;

    lane_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane the arbitration rules pick, or -1 if nobody is requesting.
    function automatic int pick(input logic [3:0] v, input int p);
`ifdef LANE_RR_ARBITER_PRIO0_EN
        if (v[0]) return 0;
        for (int k = 0; k < 4; k++) begin
            int lane;
            lane = (p + k) % 4;
            if (lane != 0 && v[lane]) return lane;
        end
`else
        for (int k = 0; k < 4; k++) begin
            int lane;
            lane = (p + k) % 4;
            if (v[lane]) return lane;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_id = 0;
    endtask

    task automatic check_out(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        check({tag, "_data"},  {24'd0, out_data},  {24'd0, m_data});
        check({tag, "_id"},    {30'd0, out_id},    m_id);
    endtask

    // One clock cycle: drive at negedge, check grant, clock, check output register.
    task automatic step(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input logic ordy,
                        input string tag);
        int g;
        logic acc;
        logic [3:0] exp_rdy;
        logic [7:0] d [4];
        @(negedge clk);
        in_valid = v; in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
        out_ready = ordy;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        #1;
        g   = pick(v, m_ptr);
        acc = !m_valid || ordy;
        exp_rdy = (g >= 0 && acc) ? (4'b0001 << g) : 4'b0000;
        check({tag, "_rdy"}, {28'd0, in_ready}, {28'd0, exp_rdy});
        @(posedge clk);
        if (g >= 0 && acc) begin
            m_valid = 1'b1;
            m_data  = d[g];
            m_id    = g;
`ifdef LANE_RR_ARBITER_PRIO0_EN
            if (g != 0) m_ptr = (g + 1) % 4;
`else
            m_ptr = (g + 1) % 4;
`endif
        end else if (acc) begin
            m_valid = 1'b0;
        end
        #1;
        check_out(tag);
    endtask

    initial begin
        int exp_ids [5];
        reset = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        in_data0 = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00; in_data3 = 8'h00;
        model_reset();
        #12;
        check_out("rst");
        check("rst_rdy", {28'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef LANE_RR_ARBITER_PRIO0_EN
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1, "prio");
            check("prio_id0", {30'd0, out_id}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b1110, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1, "prio_rr");
            check("prio_rr_seq", {30'd0, out_id}, i + 1);
        end
`else
        exp_ids = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1, "fair");
            check("fair_seq_id", {30'd0, out_id}, exp_ids[i]);
            check("fair_seq_data", {24'd0, out_data}, 32'hA0 + exp_ids[i]);
        end

        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b0, "bp");
            check("bp_hold", {24'd0, out_data}, 32'hA0);
        end
        step(4'b1111, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b1, "bp_rel");
        check("bp_rel_id", {30'd0, out_id}, 32'd1);

        step(4'b0100, 8'h00, 8'h00, 8'h5C, 8'h00, 1'b1, "sparse");
        check("sparse_data", {24'd0, out_data}, 32'h5C);
        step(4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b1, "after_sparse");
        check("ptr_after_sparse", {30'd0, out_id}, 32'd3);

        step(4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, "drain");
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_data", {24'd0, out_data}, 32'hC3);
`endif

        // Mid-cycle asynchronous reset with a stalled word in the register.
        step(4'b1111, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 1'b0, "pre_rst");
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_out("async_rst");
        check("async_rst_rdy", {28'd0, in_ready}, 32'd0);
        #1;
        reset = 1'b0;
        step(4'b0110, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b1, "post_rst");
        check("post_rst_id", {30'd0, out_id}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
